// File: rtl/bfp_expand_if.sv
// Handshake bundle for bfp_expand: upstream sample/exponent side and downstream expanded side.
// BFP_EXPAND_SATCNT_EN adds the per-frame saturation count output.
interface bfp_expand_if #(
    parameter int IWID = 12,
    parameter int OWID = 16,
    parameter int EWID = 4
);
    logic            i_valid;
    logic            o_ready;
    logic [IWID-1:0] i_data;
    logic [EWID-1:0] i_exp;
    logic            o_valid;
    logic            i_ready;
    logic [OWID-1:0] o_data;
    logic            o_last;
    logic            o_sat;
    logic            o_exp_err;
`ifdef BFP_EXPAND_SATCNT_EN
    logic [15:0]     o_sat_count;

    modport slave (
        input  i_valid, i_data, i_exp, i_ready,
        output o_ready, o_valid, o_data, o_last, o_sat, o_exp_err, o_sat_count
    );
    modport master (
        output i_valid, i_data, i_exp, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_sat, o_exp_err, o_sat_count
    );
`else
    modport slave (
        input  i_valid, i_data, i_exp, i_ready,
        output o_ready, o_valid, o_data, o_last, o_sat, o_exp_err
    );
    modport master (
        output i_valid, i_data, i_exp, i_ready,
        input  o_ready, o_valid, o_data, o_last, o_sat, o_exp_err
    );
`endif
endinterface

// File: rtl/bfp_expand.sv
// Block-floating-point expander: restores reduced-width samples by a per-frame left shift, saturating.
// Optional BFP_EXPAND_SATCNT_EN adds o_sat_count (per-frame saturated-sample count).
module bfp_expand #(
    parameter int IWID     = 12,
    parameter int OWID     = 16,
    parameter int MAXSHIFT = 6,
    parameter int LGN      = 12
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    bfp_expand_if.slave   io_bus
);
    localparam int EWID = $clog2(MAXSHIFT + 1) + 1;
    localparam int PW   = IWID + MAXSHIFT;
    localparam int XW   = (PW > OWID) ? PW : OWID;
    localparam int CW   = (LGN > 0) ? LGN : 1;

    localparam logic [CW-1:0]          LAST_CNT = CW'((1 << LGN) - 1);
    localparam logic [EWID-1:0]        EMAX     = EWID'(MAXSHIFT);
    localparam logic signed [XW-1:0]   POS_LIM  = {{(XW-OWID+1){1'b0}}, {(OWID-1){1'b1}}};
    localparam logic signed [XW-1:0]   NEG_LIM  = ~POS_LIM;

    typedef enum logic {IDLE, FRAME} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [EWID-1:0]  r_exp;
    logic             r_valid;
    logic [OWID-1:0]  r_data;
    logic             r_last;
    logic             r_sat;
    logic             r_exp_err;

    logic             w_ready;
    logic             w_accept;
    logic             w_exp_over;
    logic [EWID-1:0]  w_exp_new;
    logic [EWID-1:0]  w_exp;
    logic             w_is_last;
    logic signed [XW-1:0] w_ext;
    logic signed [XW-1:0] w_prod;
    logic [OWID-1:0]  w_sat_data;
    logic             w_sat;

    assign w_ready    = !r_valid || io_bus.i_ready;
    assign w_accept   = io_bus.i_valid && w_ready;
    assign w_exp_over = io_bus.i_exp > EMAX;
    assign w_exp_new  = w_exp_over ? EMAX : io_bus.i_exp;
    // First sample of a frame shifts by the exponent arriving with it, not the stale latch
    assign w_exp      = (r_state == IDLE) ? w_exp_new : r_exp;
    assign w_is_last  = (r_cnt == LAST_CNT);
    assign w_ext      = XW'($signed(io_bus.i_data));
    assign w_prod     = w_ext <<< w_exp;

    always_comb begin
        w_sat      = 1'b1;
        w_sat_data = w_prod[OWID-1:0];
        if (w_prod > POS_LIM) begin
            w_sat_data = POS_LIM[OWID-1:0];
        end else if (w_prod < NEG_LIM) begin
            w_sat_data = NEG_LIM[OWID-1:0];
        end else begin
            w_sat = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_sat     <= 1'b0;
            r_exp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= w_sat_data;
                r_sat   <= w_sat;
                r_last  <= w_is_last;
                r_cnt   <= w_is_last ? '0 : r_cnt + CW'(1);
                r_state <= w_is_last ? IDLE : FRAME;
                if (r_state == IDLE) begin
                    r_exp <= w_exp_new;
                    if (w_exp_over) r_exp_err <= 1'b1;
                end
            end else if (io_bus.i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign io_bus.o_ready   = w_ready;
    assign io_bus.o_valid   = r_valid;
    assign io_bus.o_data    = r_data;
    assign io_bus.o_last    = r_last;
    assign io_bus.o_sat     = r_sat;
    assign io_bus.o_exp_err = r_exp_err;

`ifdef BFP_EXPAND_SATCNT_EN
    logic [15:0] r_sat_cnt;

    // Counts consumed samples; the presented last sample is folded in so the total is complete with o_last
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sat_cnt <= '0;
        end else if (r_valid && io_bus.i_ready) begin
            if (r_last) begin
                r_sat_cnt <= '0;
            end else if (r_sat && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    assign io_bus.o_sat_count = (r_valid && r_last && r_sat && (r_sat_cnt != '1)) ?
                                r_sat_cnt + 16'd1 : r_sat_cnt;
`endif
endmodule

// File: tb/tb_bfp_expand.sv
// Self-checking bench for bfp_expand (8-sample frames) against an arithmetic reference model.
// Build with BFP_EXPAND_SATCNT_EN defined to also exercise o_sat_count.
module tb_bfp_expand;
    localparam int IWID      = 12;
    localparam int OWID      = 16;
    localparam int MAXSHIFT  = 6;
    localparam int LGN       = 3;
    localparam int EWID      = 4;
    localparam int FRAME_LEN = 1 << LGN;

    typedef struct packed {
        logic [15:0] d;
        logic        sat;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bfp_expand_if #(.IWID(IWID), .OWID(OWID), .EWID(EWID)) bus ();

    bfp_expand #(.IWID(IWID), .OWID(OWID), .MAXSHIFT(MAXSHIFT), .LGN(LGN)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .io_bus    (bus)
    );

    int   nvec = 0;
    int   nerr = 0;
    exp_t sb[$];
    int   m_cnt = 0;
    int   m_exp = 0;
    bit   m_err = 1'b0;
    bit   acc, cons;
    exp_t obs, ex;

    function automatic exp_t model_accept(input logic [11:0] d, input logic [3:0] e);
        exp_t r;
        int   p;
        if (m_cnt == 0) begin
            m_exp = (int'(e) > MAXSHIFT) ? MAXSHIFT : int'(e);
            if (int'(e) > MAXSHIFT) m_err = 1'b1;
        end
        p = int'($signed(d)) * (1 << m_exp);
        if (p > 32767) begin
            r.d = 16'h7FFF; r.sat = 1'b1;
        end else if (p < -32768) begin
            r.d = 16'h8000; r.sat = 1'b1;
        end else begin
            r.d = 16'(p); r.sat = 1'b0;
        end
        r.last = (m_cnt == FRAME_LEN - 1);
        m_cnt  = (m_cnt + 1) % FRAME_LEN;
        return r;
    endfunction

    task automatic step(input bit v, input logic [11:0] d, input logic [3:0] e, input bit rdy,
                        output bit a, output bit c, output exp_t o);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_exp   = e;
        bus.i_ready = rdy;
        #1;
        a = bus.i_valid && bus.o_ready;
        c = bus.o_valid && bus.i_ready;
        o = '{d: bus.o_data, sat: bus.o_sat, last: bus.o_last};
        if (a) sb.push_back(model_accept(d, e));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_exp = '0; bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if ({bus.o_valid, bus.o_data, bus.o_last, bus.o_sat, bus.o_exp_err, bus.o_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset_state got v=%b d=%h l=%b s=%b err=%b rdy=%b required 0/0000/0/0/0/1",
                     bus.o_valid, bus.o_data, bus.o_last, bus.o_sat, bus.o_exp_err, bus.o_ready);
        end
`ifdef BFP_EXPAND_SATCNT_EN
        nvec++;
        if (bus.o_sat_count !== 16'h0) begin
            nerr++; $display("FAIL reset_satcnt got %h required 0000", bus.o_sat_count);
        end
`endif
        sb.delete(); m_cnt = 0; m_exp = 0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int got = 0;
        for (int c = 0; c < 20 && got < FRAME_LEN; c++) begin
            step(c < FRAME_LEN, 12'h7FF, 4'd4, 1'b1, acc, cons, obs);
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex || obs !== {16'h7FF0, 1'b0, got == FRAME_LEN - 1}) begin
                    nerr++;
                    $display("FAIL basic[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                got++;
            end
        end
        nvec++;
        if (got !== FRAME_LEN) begin nerr++; $display("FAIL basic_count got %0d required %0d", got, FRAME_LEN); end
    endtask

    task automatic test_saturation();
        int          got = 0, sent = 0;
        logic [11:0] dv;
        logic [3:0]  ev;
        logic [16:0] kexp;
        for (int c = 0; c < 40 && got < 3 * FRAME_LEN; c++) begin
            case (sent)
                0, 16:   dv = (sent == 0) ? 12'h7FF : 12'hFFF;
                1, 8:    dv = 12'h800;
                default: dv = 12'($urandom);
            endcase
            ev = (sent < 8) ? 4'd5 : (sent < 16) ? 4'd4 : 4'd3;
            step(sent < 3 * FRAME_LEN, dv, ev, 1'b1, acc, cons, obs);
            if (acc) sent++;
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex) begin
                    nerr++;
                    $display("FAIL sat_model[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                if (got == 0 || got == 1 || got == 8 || got == 16) begin
                    case (got)
                        0:       kexp = {16'h7FFF, 1'b1};
                        1:       kexp = {16'h8000, 1'b1};
                        8:       kexp = {16'h8000, 1'b0};
                        default: kexp = {16'hFFF8, 1'b0};
                    endcase
                    nvec++;
                    if ({obs.d, obs.sat} !== kexp) begin
                        nerr++;
                        $display("FAIL sat_boundary[%0d] got d=%h s=%b required d=%h s=%b",
                                 got, obs.d, obs.sat, kexp[16:1], kexp[0]);
                    end
                end
                got++;
            end
        end
        nvec++;
        if (got !== 3 * FRAME_LEN) begin nerr++; $display("FAIL sat_count got %0d required %0d", got, 3 * FRAME_LEN); end
    endtask

    task automatic test_exp_clamp();
        int         got = 0, sent = 0;
        logic [3:0] ev;
        for (int c = 0; c < 30 && got < 2 * FRAME_LEN; c++) begin
            if (sent == 0)              ev = 4'd7;
            else if (sent == FRAME_LEN) ev = 4'd2;
            else                        ev = 4'($urandom_range(0, 15));
            step(sent < 2 * FRAME_LEN, 12'h001, ev, 1'b1, acc, cons, obs);
            if (acc) sent++;
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex || obs.d !== ((got < FRAME_LEN) ? 16'h0040 : 16'h0004)) begin
                    nerr++;
                    $display("FAIL clamp[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                if (got == 0 || got == FRAME_LEN + 3) begin
                    nvec++;
                    if (bus.o_exp_err !== 1'b1) begin
                        nerr++; $display("FAIL exp_err_sticky[%0d] got %b required 1", got, bus.o_exp_err);
                    end
                end
                got++;
            end
        end
        nvec++;
        if (got !== 2 * FRAME_LEN) begin nerr++; $display("FAIL clamp_count got %0d required %0d", got, 2 * FRAME_LEN); end
    endtask

    task automatic test_backpressure();
        int          got = 0, sent = 0;
        logic [11:0] dv[FRAME_LEN];
        logic [3:0]  ev;
        exp_t        prev;
        bit          rdy;
        ev = 4'($urandom_range(0, MAXSHIFT));
        for (int i = 0; i < FRAME_LEN; i++) dv[i] = 12'($urandom);
        prev = '0;
        for (int c = 0; c < 40 && got < FRAME_LEN; c++) begin
            rdy = !(c >= 3 && c < 8);
            step(sent < FRAME_LEN, dv[(sent < FRAME_LEN) ? sent : 0], ev, rdy, acc, cons, obs);
            if (acc) sent++;
            if (c > 3 && c < 8) begin
                nvec++;
                if (bus.o_ready !== 1'b0 || obs !== prev) begin
                    nerr++;
                    $display("FAIL stall[%0d] got rdy=%b d=%h l=%b required rdy=0 d=%h l=%b",
                             c, bus.o_ready, obs.d, obs.last, prev.d, prev.last);
                end
            end
            prev = obs;
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex || obs.last !== (got == FRAME_LEN - 1)) begin
                    nerr++;
                    $display("FAIL bp[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                got++;
            end
        end
        nvec++;
        if (got !== FRAME_LEN || sb.size() != 0) begin
            nerr++; $display("FAIL bp_count got %0d pending %0d required %0d pending 0", got, sb.size(), FRAME_LEN);
        end
    endtask

    task automatic test_reset_midframe();
        int got = 0, sent = 0;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 12'($urandom), 4'd3, 1'b1, acc, cons, obs);
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex) begin
                    nerr++; $display("FAIL prereset[%0d] got d=%h required d=%h", c, obs.d, ex.d);
                end
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({bus.o_valid, bus.o_data, bus.o_last, bus.o_sat, bus.o_exp_err} !== 20'h0) begin
            nerr++;
            $display("FAIL midreset_state got v=%b d=%h l=%b s=%b err=%b required all 0",
                     bus.o_valid, bus.o_data, bus.o_last, bus.o_sat, bus.o_exp_err);
        end
        sb.delete(); m_cnt = 0; m_exp = 0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20 && got < FRAME_LEN; c++) begin
            step(sent < FRAME_LEN, 12'($urandom), (sent == 0) ? 4'd1 : 4'd5, 1'b1, acc, cons, obs);
            if (acc) sent++;
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex || obs.last !== (got == FRAME_LEN - 1)) begin
                    nerr++;
                    $display("FAIL postreset[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                got++;
            end
        end
        nvec++;
        if (got !== FRAME_LEN) begin nerr++; $display("FAIL postreset_count got %0d required %0d", got, FRAME_LEN); end
    endtask

`ifdef BFP_EXPAND_SATCNT_EN
    task automatic test_satcnt();
        int          got = 0, sent = 0, fsat = 0;
        logic [11:0] dv;
        for (int c = 0; c < 40 && got < 2 * FRAME_LEN; c++) begin
            dv = (sent == 1 || sent == 3 || sent == 7) ? 12'h7FF : 12'h001;
            step(sent < 2 * FRAME_LEN, dv, 4'd6, 1'b1, acc, cons, obs);
            if (acc) sent++;
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex) begin
                    nerr++; $display("FAIL satcnt_data[%0d] got d=%h required d=%h", got, obs.d, ex.d);
                end
                if (got < FRAME_LEN && ex.sat) fsat++;
                if (got == FRAME_LEN - 1) begin
                    nvec++;
                    if (bus.o_sat_count !== 16'(fsat) || !bus.o_last) begin
                        nerr++; $display("FAIL satcnt_last got %0d last=%b required %0d last=1", bus.o_sat_count, bus.o_last, fsat);
                    end
                end
                if (got == FRAME_LEN) begin
                    nvec++;
                    if (bus.o_sat_count !== 16'h0) begin
                        nerr++; $display("FAIL satcnt_clear got %0d required 0", bus.o_sat_count);
                    end
                end
                got++;
            end
        end
    endtask
`endif

    task automatic test_random();
        int          got = 0, sent = 0;
        logic [11:0] dv;
        logic [3:0]  ev;
        localparam int N = 5 * FRAME_LEN;
        dv = 12'($urandom);
        ev = 4'($urandom_range(0, 7));
        for (int c = 0; c < 600 && !(sent == N && sb.size() == 0); c++) begin
            step((sent < N) && ($urandom_range(0, 3) != 0), dv, ev, $urandom_range(0, 3) != 0, acc, cons, obs);
            if (acc) begin
                sent++;
                dv = 12'($urandom);
                ev = 4'($urandom_range(0, 7));
            end
            if (cons) begin
                nvec++;
                ex = (sb.size() > 0) ? sb.pop_front() : '0;
                if (obs !== ex) begin
                    nerr++;
                    $display("FAIL random[%0d] got d=%h s=%b l=%b required d=%h s=%b l=%b",
                             got, obs.d, obs.sat, obs.last, ex.d, ex.sat, ex.last);
                end
                got++;
            end
        end
        nvec++;
        if (got !== N || bus.o_exp_err !== m_err) begin
            nerr++; $display("FAIL random_end got n=%0d err=%b required n=%0d err=%b", got, bus.o_exp_err, N, m_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_exp_clamp();
        test_backpressure();
        test_reset_midframe();
`ifdef BFP_EXPAND_SATCNT_EN
        test_satcnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
